// File: rtl/inst_fetch_queue.sv
// Purpose: owns the PC, reads two sequential words per cycle from the instruction ROM, and queues them for dual-issue decode.
// Latency: an instruction appears on out_* one cycle after the ROM cycle that fetched it.
// Backpressure: fetch stops while stalled or while the queue has fewer than two free slots; decode pops 0..2 per cycle.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   flush, flush_pc          redirect; target is forced to word alignment
//   stall                    freezes fetch and dequeue
//   rom_ce, rom_addr         ROM enable / byte address (rom_addr is always the PC)
//   rom_inst1, rom_inst2     ROM words at rom_addr and rom_addr+4 (same cycle)
//   issue_cnt                entries taken by decode this cycle (3 acts as 2)
//   out_valid/inst/pc 1,2    head and head+1 entries, zeroed when not valid
//   queue_count              current occupancy
module inst_fetch_queue #(
    parameter int          QUEUE_DEPTH = 8,             // power of two, >= 4
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [31:0]                   flush_pc,
    input  logic                          stall,
    output logic                          rom_ce,
    output logic [31:0]                   rom_addr,
    input  logic [31:0]                   rom_inst1,
    input  logic [31:0]                   rom_inst2,
    input  logic [1:0]                    issue_cnt,
    output logic                          out_valid1,
    output logic [31:0]                   out_inst1,
    output logic [31:0]                   out_pc1,
    output logic                          out_valid2,
    output logic [31:0]                   out_inst2,
    output logic [31:0]                   out_pc2,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    // Fetch needs room for both words, judged on the pre-pop occupancy.
    localparam logic [CW-1:0] FETCH_LIMIT = CW'(QUEUE_DEPTH - 2);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t          q_mem [QUEUE_DEPTH];
    logic [31:0]     pc;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    logic            fetch;
    logic [1:0]      issue_eff;
    logic [1:0]      pop;
    logic [PW-1:0]   head_p1;
    logic [PW-1:0]   tail_p1;
    logic [CW-1:0]   count_next;

    assign fetch    = !rst && !flush && !stall && (count <= FETCH_LIMIT);
    assign rom_ce   = fetch;
    assign rom_addr = pc;

    assign head_p1  = head + PW'(1);
    assign tail_p1  = tail + PW'(1);

    // Decode may ask for more than is queued; never pop past what exists.
    always_comb begin
        issue_eff = (issue_cnt == 2'd3) ? 2'd2 : issue_cnt;
        pop       = 2'd0;
        if (!stall && !flush) begin
            pop = (CW'(issue_eff) > count) ? count[1:0] : issue_eff;
        end
    end

    assign count_next = count + (fetch ? CW'(2) : CW'(0)) - CW'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            pc    <= {flush_pc[31:2], 2'b00};
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop);
            count <= count_next;
            if (fetch) begin
                tail <= tail + PW'(2);
                pc   <= pc + 32'd8;
            end
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (fetch) begin
            q_mem[tail]    <= '{inst: rom_inst1, pc: pc};
            q_mem[tail_p1] <= '{inst: rom_inst2, pc: pc + 32'd4};
        end
    end

    assign queue_count = count;
    assign out_valid1  = (count != '0);
    assign out_valid2  = (count >= CW'(2));
    assign out_inst1   = out_valid1 ? q_mem[head].inst    : 32'd0;
    assign out_pc1     = out_valid1 ? q_mem[head].pc      : 32'd0;
    assign out_inst2   = out_valid2 ? q_mem[head_p1].inst : 32'd0;
    assign out_pc2     = out_valid2 ? q_mem[head_p1].pc   : 32'd0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Purpose: self-checking bench for inst_fetch_queue against a queue-based reference model.
// Latency: checks outputs one cycle after each fetching ROM cycle.
// Backpressure: exercises stall, full queue, flush and randomized issue counts.
module tb_inst_fetch_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'd0;
    logic        stall = 1'b0;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst1, rom_inst2;
    logic [1:0]  issue_cnt = 2'd0;
    logic        out_valid1, out_valid2;
    logic [31:0] out_inst1, out_pc1, out_inst2, out_pc2;
    logic [3:0]  queue_count;

    int checks = 0;
    int errors = 0;

    // Reference model: queued entries in age order, plus the fetch PC.
    logic [31:0] mq_inst[$];
    logic [31:0] mq_pc[$];
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    // ROM holds word index at each word address: word[i] = i.
    assign rom_inst1 = rom_addr >> 2;
    assign rom_inst2 = (rom_addr + 32'd4) >> 2;

    inst_fetch_queue #(.QUEUE_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc), .stall(stall),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst1(rom_inst1), .rom_inst2(rom_inst2),
        .issue_cnt(issue_cnt),
        .out_valid1(out_valid1), .out_inst1(out_inst1), .out_pc1(out_pc1),
        .out_valid2(out_valid2), .out_inst2(out_inst2), .out_pc2(out_pc2),
        .queue_count(queue_count)
    );

    task automatic model_reset();
        mq_inst.delete();
        mq_pc.delete();
        m_pc = 32'h0000_0000;
    endtask

    // Advance one clock; the model applies this cycle's inputs.
    task automatic tick();
        int sz;
        int npop;
        bit f;
        sz = mq_pc.size();
        f  = !flush && !stall && (DEPTH - sz >= 2);
        if (flush) begin
            mq_inst.delete();
            mq_pc.delete();
            m_pc = {flush_pc[31:2], 2'b00};
        end else begin
            npop = stall ? 0 : ((issue_cnt == 2'd3) ? 2 : int'(issue_cnt));
            if (npop > sz) npop = sz;
            repeat (npop) begin
                void'(mq_inst.pop_front());
                void'(mq_pc.pop_front());
            end
            if (f) begin
                mq_pc.push_back(m_pc);
                mq_inst.push_back(m_pc >> 2);
                mq_pc.push_back(m_pc + 32'd4);
                mq_inst.push_back((m_pc + 32'd4) >> 2);
                m_pc = m_pc + 32'd8;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; stall = 1'b0; issue_cnt = 2'd0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #12;
        checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL reset_rom_ce: got %0h want 0", rom_ce); end
        checks++; if (queue_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", queue_count); end
        checks++; if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b%b want 00", out_valid1, out_valid2); end
        checks++; if (out_inst1 !== 32'd0 || out_pc2 !== 32'd0) begin errors++; $display("FAIL reset_fields: got %h %h want 0 0", out_inst1, out_pc2); end
        checks++; if (rom_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", rom_addr); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        issue_cnt = 2'd2;
        #1;
        checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'd0) begin errors++; $display("FAIL stream_c0: got ce=%0h addr=%h want ce=1 addr=0", rom_ce, rom_addr); end
        tick();
        checks++; if (out_inst1 !== 32'd0 || out_pc1 !== 32'd0) begin errors++; $display("FAIL stream_head: got %h/%h want 0/0", out_inst1, out_pc1); end
        checks++; if (out_valid2 !== 1'b1 || out_inst2 !== 32'd1 || out_pc2 !== 32'd4) begin errors++; $display("FAIL stream_second: got v=%0h %h/%h want 1 1/4", out_valid2, out_inst2, out_pc2); end
        tick();
        checks++; if (rom_addr !== 32'h10) begin errors++; $display("FAIL stream_c2_addr: got %h want 10", rom_addr); end
        for (int k = 2; k < 7; k++) begin
            checks++; if (queue_count !== 4'd2 || out_pc1 !== 32'(8 * (k - 1))) begin errors++; $display("FAIL stream_steady: got cnt=%0d pc=%h want 2 %h", queue_count, out_pc1, 8 * (k - 1)); end
            tick();
        end
    endtask

    task automatic test_full();
        apply_reset();
        issue_cnt = 2'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'(8 * i)) begin errors++; $display("FAIL full_fetch: got ce=%0h addr=%h want 1 %h", rom_ce, rom_addr, 8 * i); end
            tick();
        end
        checks++; if (rom_ce !== 1'b0 || queue_count !== 4'd8) begin errors++; $display("FAIL full_stop: got ce=%0h cnt=%0d want 0 8", rom_ce, queue_count); end
        issue_cnt = 2'd2;
        tick();
        issue_cnt = 2'd0;
        #1;
        checks++; if (queue_count !== 4'd6 || rom_ce !== 1'b1 || rom_addr !== 32'h20) begin errors++; $display("FAIL full_resume: got cnt=%0d ce=%0h addr=%h want 6 1 20", queue_count, rom_ce, rom_addr); end
        tick();
    endtask

    task automatic test_flush();
        apply_reset();
        issue_cnt = 2'd0;
        tick(); tick();
        issue_cnt = 2'd1;
        tick();
        checks++; if (queue_count !== 4'd5) begin errors++; $display("FAIL flush_pre: got %0d want 5", queue_count); end
        flush = 1'b1; flush_pc = 32'h0000_0107; issue_cnt = 2'd2;
        #1;
        checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL flush_no_ce: got %0h want 0", rom_ce); end
        tick();
        flush = 1'b0; issue_cnt = 2'd0;
        #1;
        checks++; if (queue_count !== 4'd0 || rom_addr !== 32'h104 || rom_ce !== 1'b1) begin errors++; $display("FAIL flush_redirect: got cnt=%0d addr=%h ce=%0h want 0 104 1", queue_count, rom_addr, rom_ce); end
        tick();
        checks++; if (out_pc1 !== 32'h104 || out_pc2 !== 32'h108 || out_inst1 !== 32'h41) begin errors++; $display("FAIL flush_target: got %h %h %h want 104 108 41", out_pc1, out_pc2, out_inst1); end
    endtask

    task automatic test_stall();
        issue_cnt = 2'd0;
        tick();
        stall = 1'b1; issue_cnt = 2'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rom_ce !== 1'b0 || queue_count !== 4'd4 || out_pc1 !== 32'h104 || rom_addr !== 32'h114) begin errors++; $display("FAIL stall_hold: got ce=%0h cnt=%0d pc1=%h addr=%h want 0 4 104 114", rom_ce, queue_count, out_pc1, rom_addr); end
            tick();
        end
        stall = 1'b0;
        #1;
        checks++; if (rom_ce !== 1'b1) begin errors++; $display("FAIL stall_release_ce: got %0h want 1", rom_ce); end
        tick();
        checks++; if (queue_count !== 4'd4 || out_pc1 !== 32'h10C) begin errors++; $display("FAIL stall_resume: got cnt=%0d pc1=%h want 4 10c", queue_count, out_pc1); end
    endtask

    task automatic test_clamp();
        flush = 1'b1; flush_pc = 32'h200; issue_cnt = 2'd3;
        tick();
        flush = 1'b0; issue_cnt = 2'd2;
        tick();
        checks++; if (queue_count !== 4'd2 || out_pc1 !== 32'h200) begin errors++; $display("FAIL clamp_empty: got cnt=%0d pc1=%h want 2 200", queue_count, out_pc1); end
        issue_cnt = 2'd0;
        tick();
        issue_cnt = 2'd3;
        tick();
        checks++; if (queue_count !== 4'd4 || out_pc1 !== 32'h208) begin errors++; $display("FAIL clamp_three: got cnt=%0d pc1=%h want 4 208", queue_count, out_pc1); end
        issue_cnt = 2'd0;
        tick(); tick();
        issue_cnt = 2'd1;
        tick();
        checks++; if (queue_count !== 4'd7) begin errors++; $display("FAIL clamp_full_pop1: got %0d want 7", queue_count); end
        issue_cnt = 2'd3;
        tick();
        checks++; if (queue_count !== 4'd5 || out_pc1 !== mq_pc[0]) begin errors++; $display("FAIL clamp_full_pop2: got cnt=%0d pc1=%h want 5 %h", queue_count, out_pc1, mq_pc[0]); end
    endtask

    task automatic test_wrap();
        flush = 1'b1; flush_pc = 32'hFFFF_FFF8; issue_cnt = 2'd0;
        tick();
        flush = 1'b0;
        #1;
        checks++; if (rom_addr !== 32'hFFFF_FFF8 || rom_ce !== 1'b1) begin errors++; $display("FAIL wrap_addr: got %h ce=%0h want fffffff8 1", rom_addr, rom_ce); end
        tick();
        checks++; if (out_pc1 !== 32'hFFFF_FFF8 || out_pc2 !== 32'hFFFF_FFFC || rom_addr !== 32'd0) begin errors++; $display("FAIL wrap_pcs: got %h %h addr=%h want fffffff8 fffffffc 0", out_pc1, out_pc2, rom_addr); end
        tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++; if (queue_count !== 4'd0 || out_valid1 !== 1'b0 || rom_ce !== 1'b0) begin errors++; $display("FAIL async_reset: got cnt=%0d v1=%0h ce=%0h want 0 0 0", queue_count, out_valid1, rom_ce); end
        #2 rst = 1'b0;
        #1;
        checks++; if (rom_addr !== 32'd0 || rom_ce !== 1'b1) begin errors++; $display("FAIL reset_refetch: got %h ce=%0h want 0 1", rom_addr, rom_ce); end
    endtask

    task automatic test_random();
        logic        e_ce;
        logic [31:0] e_i1, e_p1, e_i2, e_p2;
        int          sz;
        for (int n = 0; n < 400; n++) begin
            flush     = ($urandom_range(0, 19) == 0);
            flush_pc  = $urandom;
            stall     = ($urandom_range(0, 4) == 0);
            issue_cnt = 2'($urandom_range(0, 3));
            #1;
            sz   = mq_pc.size();
            e_ce = !flush && !stall && (DEPTH - sz >= 2);
            e_i1 = (sz >= 1) ? mq_inst[0] : 32'd0;
            e_p1 = (sz >= 1) ? mq_pc[0]   : 32'd0;
            e_i2 = (sz >= 2) ? mq_inst[1] : 32'd0;
            e_p2 = (sz >= 2) ? mq_pc[1]   : 32'd0;
            checks++;
            if (rom_ce !== e_ce || rom_addr !== m_pc || int'(queue_count) != sz
                || out_valid1 !== (sz >= 1) || out_valid2 !== (sz >= 2)
                || out_inst1 !== e_i1 || out_pc1 !== e_p1 || out_inst2 !== e_i2 || out_pc2 !== e_p2) begin
                errors++;
                $display("FAIL random_cycle%0d: got ce=%0h addr=%h cnt=%0d h=%h/%h n=%h/%h want ce=%0h addr=%h cnt=%0d h=%h/%h n=%h/%h",
                         n, rom_ce, rom_addr, queue_count, out_inst1, out_pc1, out_inst2, out_pc2,
                         e_ce, m_pc, sz, e_i1, e_p1, e_i2, e_p2);
            end
            tick();
        end
        flush = 1'b0; stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_flush();
        test_stall();
        test_clamp();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
